md_issue_ctrl: RTL and testbench
================================

Name: md_issue_ctrl

Overview:
- E-stage issue controller directly upstream of the multiply/divide unit in the P7 pipeline.
- Owns the E-stage slot for HI/LO-class instructions (mult, multu, div, divu, mfhi, mflo, mthi, mtlo). Drives the unit's operands, opcode and start strobes.
- Keeps a shadow busy countdown to produce the D-stage stall, and cross-checks it against the unit's own busy output.
- Honours the interrupt/exception request: an issue in the same cycle as a request is cancelled and the E slot is flushed.

Parameters:
- MUL_LAT, 5, busy cycles after a multiply issue (cycles after the start cycle).
- DIV_LAT, 10, busy cycles after a divide issue.
- CNT_W, 4, countdown width; must hold max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- d_valid  in  1  D-stage instruction valid
- d_op  in  4  D-stage HI/LO op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NONE
- d_a  in  32  forwarded rs value
- d_b  in  32  forwarded rt value
- flush_e  in  1  insert bubble into E (branch/other hazard)
- req  in  1  interrupt/exception request; cancels the E-stage issue
- md_busy  in  1  busy output of the multiply/divide unit
- stall_d  out  1  freeze F/D; E receives a bubble
- md_mul  out  1  multiply start strobe to the unit
- md_div  out  1  divide start strobe to the unit
- md_op  out  4  E-slot op code (0 when the slot is empty)
- md_a  out  32  E-slot operand A
- md_b  out  32  E-slot operand B
- e_is_mf  out  1  E slot holds MFHI/MFLO (for the result mux downstream)
- cnt  out  CNT_W  shadow busy countdown
- stall_cycles  out  32  saturating count of stall cycles
- sync_err  out  1  sticky: shadow busy disagreed with md_busy

Behaviour:
- Definitions:
  - d_md = d_valid and d_op in 1..8.
  - e_start = md_op in 1..4.
  - shadow_busy = (cnt != 0).
- stall_d (combinational) = d_md and (e_start or shadow_busy).
  - Any HI/LO-class instruction (including mf/mt) waits while a mult/div is starting or running.
  - Non-HI/LO instructions never stall here.
- md_mul = (md_op == 1 or 2); md_div = (md_op == 3 or 4). Both are asserted regardless of req, matching the unit's interface, since the unit gates its own state on req.
- E-slot register (md_op, md_a, md_b), updated every posedge:
  - reset: md_op = 0, md_a = 0, md_b = 0.
  - else if req or flush_e or stall_d: md_op = 0; md_a and md_b hold.
  - else if d_md: load d_op, d_a, d_b.
  - else: md_op = 0.
- Countdown cnt:
  - reset: 0.
  - else if e_start and not req: load MUL_LAT for op 1/2, DIV_LAT for op 3/4.
  - else if cnt != 0: decrement.
  - e_start is never true while cnt != 0, because stall_d blocks it; no reload-while-busy case exists.
  - req while cnt != 0: keep decrementing. An operation already in flight is not cancelled.
- Cycle timing:
  - Issue cycle T has e_start = 1.
  - Cycles T+1 .. T+LAT have cnt = LAT .. 1.
  - cnt = 0 at T+LAT+1; the next HI/LO op may enter E at T+LAT+1.
- stall_cycles:
  - reset: 0.
  - Increment when stall_d = 1 and req = 0; saturate at 32'hFFFFFFFF.
- sync_err:
  - reset: 0.
  - Set when md_busy != shadow_busy; cleared only by reset.
- e_is_mf = (md_op == 5 or 6).
- Reset mid-operation: all state cleared in the same edge; stall_d drops immediately once reset deasserts with an empty slot.

Test Plan:
- mult issue: d_op = 1, d_a = 7, d_b = 6, then d_op = 5 held in D. Required: md_mul = 1 for one cycle; cnt = 5,4,3,2,1; stall_d = 1 for 6 cycles; mfhi enters E when cnt = 0; stall_cycles = 6; sync_err = 0 against a conforming unit.
- div then mtlo: d_op = 3, then d_op = 8. Required: md_div pulse; cnt starts at 10; mtlo stalled 11 cycles, then issued with md_op = 8.
- req on issue: d_op = 2 enters E and req = 1 in that same cycle. Required: cnt stays 0; next cycle md_op = 0; a following d_op = 5 is not stalled.
- req mid-divide: req = 1 at cnt = 4. Required: cnt continues 3,2,1,0; E slot flushed; stall_cycles does not count the req cycle.
- flush_e and non-HI/LO traffic: d_op = 0 while cnt = 3 gives stall_d = 0; flush_e = 1 with d_op = 1 gives md_op = 0 next cycle and no start.
- sync/reset: force md_busy = 1 while cnt = 0; sync_err sets and stays set. Apply reset at cnt = 7; next cycle cnt = 0, md_op = 0, stall_cycles = 0, sync_err = 0.

Source files
------------

// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the HI/LO multiply/divide unit: owns the E slot,
// drives unit start strobes, and keeps a shadow busy countdown for the D-stage stall.
module md_issue_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [3:0]       d_op,
    input  logic [31:0]      d_a,
    input  logic [31:0]      d_b,
    input  logic             flush_e,
    input  logic             req,
    input  logic             md_busy,
    output logic             stall_d,
    output logic             md_mul,
    output logic             md_div,
    output logic [3:0]       md_op,
    output logic [31:0]      md_a,
    output logic [31:0]      md_b,
    output logic             e_is_mf,
    output logic [CNT_W-1:0] cnt,
    output logic [31:0]      stall_cycles,
    output logic             sync_err
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic d_md;
    logic e_start;
    logic shadow_busy;

    assign d_md        = d_valid && (d_op >= OP_MULT) && (d_op <= OP_MTLO);
    assign e_start     = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    assign shadow_busy = (cnt != '0);

    // Every HI/LO-class op, including mf/mt, waits for a starting or running mult/div.
    assign stall_d = d_md && (e_start || shadow_busy);

    // Strobes are not gated by req; the unit qualifies its own state with req.
    assign md_mul  = (md_op == OP_MULT) || (md_op == OP_MULTU);
    assign md_div  = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    assign e_is_mf = (md_op == OP_MFHI) || (md_op == OP_MFLO);

    always_ff @(posedge clk) begin
        if (reset) begin
            md_op <= '0;
            md_a  <= '0;
            md_b  <= '0;
        end else if (req || flush_e || stall_d) begin
            md_op <= '0;
        end else if (d_md) begin
            md_op <= d_op;
            md_a  <= d_a;
            md_b  <= d_b;
        end else begin
            md_op <= '0;
        end
    end

    // An op already in flight is not cancelled by req; only the start is.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (e_start && !req)
            cnt <= md_mul ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
        else if (shadow_busy)
            cnt <= cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= '0;
        else if (stall_d && !req && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            sync_err <= 1'b0;
        else if (md_busy != shadow_busy)
            sync_err <= 1'b1;
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a small behavioural model of the
// multiply/divide unit supplying md_busy.
module tb_md_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_valid;
    logic [3:0]  d_op;
    logic [31:0] d_a, d_b;
    logic        flush_e, req, md_busy;
    logic        stall_d, md_mul, md_div, e_is_mf, sync_err;
    logic [3:0]  md_op, cnt;
    logic [31:0] md_a, md_b, stall_cycles;

    int n_chk = 0;
    int n_fail = 0;
    int exp_stalls = 0;

    // Unit model: busy for LAT cycles after an un-cancelled start.
    int  ub;
    logic force_busy;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset)
            ub <= 0;
        else if ((md_mul || md_div) && !req)
            ub <= md_mul ? 5 : 10;
        else if (ub != 0)
            ub <= ub - 1;
    end
    assign md_busy = force_busy || (ub != 0);

    md_issue_ctrl dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_op(d_op), .d_a(d_a), .d_b(d_b),
        .flush_e(flush_e), .req(req), .md_busy(md_busy), .stall_d(stall_d),
        .md_mul(md_mul), .md_div(md_div), .md_op(md_op), .md_a(md_a), .md_b(md_b),
        .e_is_mf(e_is_mf), .cnt(cnt), .stall_cycles(stall_cycles), .sync_err(sync_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; d_valid = 1'b0; d_op = 4'd0; d_a = '0; d_b = '0;
        flush_e = 1'b0; req = 1'b0; force_busy = 1'b0;
        tick(); tick();
        reset = 1'b0;
        settle();
        n_chk++; if (md_op !== 4'd0) begin n_fail++; $display("FAIL reset_md_op got %0d want 0", md_op); end
        n_chk++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", cnt); end
        n_chk++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cycles got %0d want 0", stall_cycles); end
        n_chk++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL reset_sync_err got %b want 0", sync_err); end
        n_chk++; if ({stall_d, md_mul, md_div, e_is_mf} !== 4'b0) begin n_fail++; $display("FAIL reset_outs got %b want 0000", {stall_d, md_mul, md_div, e_is_mf}); end
    endtask

    task automatic test_mult();
        tick();
        d_valid = 1'b1; d_op = 4'd1; d_a = 32'd7; d_b = 32'd6;
        settle();
        n_chk++; if (stall_d !== 1'b0) begin n_fail++; $display("FAIL mult_issue_stall got %b want 0", stall_d); end
        tick();
        d_op = 4'd5; d_a = 32'd11; d_b = 32'd22;
        settle();
        n_chk++; if ({md_mul, md_div, stall_d} !== 3'b101) begin n_fail++; $display("FAIL mult_start got %b want 101", {md_mul, md_div, stall_d}); end
        n_chk++; if (md_a !== 32'd7 || md_b !== 32'd6) begin n_fail++; $display("FAIL mult_operands got %0d,%0d want 7,6", md_a, md_b); end
        exp_stalls += 1;
        for (int k = 5; k >= 1; k--) begin
            tick(); settle();
            n_chk++; if (cnt !== k[3:0] || stall_d !== 1'b1 || md_mul !== 1'b0) begin
                n_fail++; $display("FAIL mult_count got cnt=%0d stall=%b mul=%b want cnt=%0d stall=1 mul=0", cnt, stall_d, md_mul, k);
            end
            n_chk++; if (md_a !== 32'd7) begin n_fail++; $display("FAIL mult_a_hold got %0d want 7", md_a); end
            exp_stalls += 1;
        end
        tick(); settle();
        n_chk++; if (cnt !== 4'd0 || stall_d !== 1'b0) begin n_fail++; $display("FAIL mult_done got cnt=%0d stall=%b want 0,0", cnt, stall_d); end
        tick();
        d_valid = 1'b0;
        settle();
        n_chk++; if (md_op !== 4'd5 || e_is_mf !== 1'b1 || md_a !== 32'd11) begin
            n_fail++; $display("FAIL mfhi_enter got op=%0d mf=%b a=%0d want op=5 mf=1 a=11", md_op, e_is_mf, md_a);
        end
        n_chk++; if (stall_cycles !== 32'd6) begin n_fail++; $display("FAIL mult_stall_cycles got %0d want 6", stall_cycles); end
        n_chk++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL mult_sync got %b want 0", sync_err); end
        tick();
    endtask

    task automatic test_div_mtlo();
        d_valid = 1'b1; d_op = 4'd3; d_a = 32'd100; d_b = 32'd7;
        tick();
        d_op = 4'd8; d_a = 32'd55;
        settle();
        n_chk++; if ({md_div, md_mul, stall_d} !== 3'b101) begin n_fail++; $display("FAIL div_start got %b want 101", {md_div, md_mul, stall_d}); end
        exp_stalls += 1;
        for (int k = 10; k >= 1; k--) begin
            tick(); settle();
            n_chk++; if (cnt !== k[3:0] || stall_d !== 1'b1) begin
                n_fail++; $display("FAIL div_count got cnt=%0d stall=%b want cnt=%0d stall=1", cnt, stall_d, k);
            end
            exp_stalls += 1;
        end
        tick(); settle();
        n_chk++; if (cnt !== 4'd0 || stall_d !== 1'b0 || md_op !== 4'd0) begin
            n_fail++; $display("FAIL div_done got cnt=%0d stall=%b op=%0d want 0,0,0", cnt, stall_d, md_op);
        end
        tick();
        d_valid = 1'b0;
        settle();
        n_chk++; if (md_op !== 4'd8 || e_is_mf !== 1'b0 || md_a !== 32'd55) begin
            n_fail++; $display("FAIL mtlo_issue got op=%0d mf=%b a=%0d want 8,0,55", md_op, e_is_mf, md_a);
        end
        n_chk++; if (stall_cycles !== exp_stalls) begin n_fail++; $display("FAIL div_stall_cycles got %0d want %0d", stall_cycles, exp_stalls); end
        tick();
    endtask

    task automatic test_req_issue();
        d_valid = 1'b1; d_op = 4'd2; d_a = 32'd3; d_b = 32'd4;
        tick();
        d_valid = 1'b0; req = 1'b1;
        settle();
        n_chk++; if (md_op !== 4'd2 || md_mul !== 1'b1) begin n_fail++; $display("FAIL req_issue_strobe got op=%0d mul=%b want 2,1", md_op, md_mul); end
        tick();
        req = 1'b0; d_valid = 1'b1; d_op = 4'd5;
        settle();
        n_chk++; if (cnt !== 4'd0 || md_op !== 4'd0 || stall_d !== 1'b0) begin
            n_fail++; $display("FAIL req_issue_cancel got cnt=%0d op=%0d stall=%b want 0,0,0", cnt, md_op, stall_d);
        end
        tick();
        d_valid = 1'b0;
        settle();
        n_chk++; if (md_op !== 4'd5) begin n_fail++; $display("FAIL req_issue_next got %0d want 5", md_op); end
        n_chk++; if (stall_cycles !== exp_stalls) begin n_fail++; $display("FAIL req_issue_stalls got %0d want %0d", stall_cycles, exp_stalls); end
        tick();
    endtask

    task automatic test_req_mid_div();
        d_valid = 1'b1; d_op = 4'd4; d_a = 32'd9; d_b = 32'd2;
        tick();
        d_op = 4'd6;
        settle();
        n_chk++; if (md_div !== 1'b1) begin n_fail++; $display("FAIL divu_start got %b want 1", md_div); end
        exp_stalls += 1;
        for (int k = 10; k >= 5; k--) begin
            tick(); settle();
            exp_stalls += 1;
        end
        tick();
        req = 1'b1;
        settle();
        n_chk++; if (cnt !== 4'd4 || stall_d !== 1'b1) begin n_fail++; $display("FAIL req_mid_at4 got cnt=%0d stall=%b want 4,1", cnt, stall_d); end
        tick();
        req = 1'b0;
        settle();
        n_chk++; if (cnt !== 4'd3 || md_op !== 4'd0) begin n_fail++; $display("FAIL req_mid_after got cnt=%0d op=%0d want 3,0", cnt, md_op); end
        n_chk++; if (stall_cycles !== exp_stalls) begin n_fail++; $display("FAIL req_mid_no_count got %0d want %0d", stall_cycles, exp_stalls); end
        exp_stalls += 1;
        for (int k = 2; k >= 0; k--) begin
            tick(); settle();
            n_chk++; if (cnt !== k[3:0]) begin n_fail++; $display("FAIL req_mid_count got %0d want %0d", cnt, k); end
            if (k != 0) exp_stalls += 1;
        end
        n_chk++; if (stall_cycles !== exp_stalls || stall_d !== 1'b0) begin
            n_fail++; $display("FAIL req_mid_end got stalls=%0d stall=%b want %0d,0", stall_cycles, stall_d, exp_stalls);
        end
        tick();
        d_valid = 1'b0;
        settle();
        n_chk++; if (md_op !== 4'd6 || e_is_mf !== 1'b1) begin n_fail++; $display("FAIL mflo_enter got op=%0d mf=%b want 6,1", md_op, e_is_mf); end
        tick();
    endtask

    task automatic test_flush_nonmd();
        d_valid = 1'b1; d_op = 4'd1;
        tick();
        d_valid = 1'b0;
        tick(); tick(); tick();
        d_valid = 1'b1; d_op = 4'd0;
        settle();
        n_chk++; if (cnt !== 4'd3 || stall_d !== 1'b0) begin n_fail++; $display("FAIL nonmd_op0 got cnt=%0d stall=%b want 3,0", cnt, stall_d); end
        tick();
        d_op = 4'd12;
        settle();
        n_chk++; if (cnt !== 4'd2 || stall_d !== 1'b0) begin n_fail++; $display("FAIL nonmd_op12 got cnt=%0d stall=%b want 2,0", cnt, stall_d); end
        tick();
        d_valid = 1'b0;
        tick();
        flush_e = 1'b1; d_valid = 1'b1; d_op = 4'd1;
        settle();
        n_chk++; if (cnt !== 4'd0 || stall_d !== 1'b0) begin n_fail++; $display("FAIL flush_pre got cnt=%0d stall=%b want 0,0", cnt, stall_d); end
        tick();
        flush_e = 1'b0; d_valid = 1'b0;
        settle();
        n_chk++; if (md_op !== 4'd0 || md_mul !== 1'b0) begin n_fail++; $display("FAIL flush_bubble got op=%0d mul=%b want 0,0", md_op, md_mul); end
        tick(); settle();
        n_chk++; if (cnt !== 4'd0 || stall_cycles !== exp_stalls) begin
            n_fail++; $display("FAIL flush_nostart got cnt=%0d stalls=%0d want 0,%0d", cnt, stall_cycles, exp_stalls);
        end
    endtask

    task automatic test_sync_reset();
        tick();
        force_busy = 1'b1;
        settle();
        n_chk++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL sync_pre got %b want 0", sync_err); end
        tick();
        force_busy = 1'b0;
        settle();
        n_chk++; if (sync_err !== 1'b1) begin n_fail++; $display("FAIL sync_set got %b want 1", sync_err); end
        tick(); settle();
        n_chk++; if (sync_err !== 1'b1) begin n_fail++; $display("FAIL sync_sticky got %b want 1", sync_err); end
        d_valid = 1'b1; d_op = 4'd3;
        tick();
        d_valid = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        settle();
        n_chk++; if (cnt !== 4'd7) begin n_fail++; $display("FAIL reset_mid_pre got cnt=%0d want 7", cnt); end
        tick();
        reset = 1'b0; d_valid = 1'b1; d_op = 4'd5;
        settle();
        n_chk++; if (cnt !== 4'd0 || md_op !== 4'd0 || stall_cycles !== 32'd0 || sync_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid got cnt=%0d op=%0d stalls=%0d err=%b want 0,0,0,0", cnt, md_op, stall_cycles, sync_err);
        end
        n_chk++; if (stall_d !== 1'b0) begin n_fail++; $display("FAIL reset_mid_stall got %b want 0", stall_d); end
        tick();
        d_valid = 1'b0;
        settle();
        n_chk++; if (md_op !== 4'd5 || sync_err !== 1'b0) begin n_fail++; $display("FAIL reset_mid_after got op=%0d err=%b want 5,0", md_op, sync_err); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div_mtlo();
        test_req_issue();
        test_req_mid_div();
        test_flush_nonmd();
        test_sync_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
